vga_timing_out: RTL and testbench
=================================

# vga_timing_out

Final video stage between the pixel generator and the DE1-SoC VGA DAC pins. It produces 640x480@60 Hz timing from CLOCK_50 using an internal divide-by-2 pixel enable. It issues pixel coordinate requests to the upstream renderer and registers the returned RGB together with HS/VS/BLANK_N so that all pin outputs are aligned. KEY[0] drives its reset at the top level.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, h front porch (pixels)
- H_SYNC, 96, h sync width (pixels)
- H_BACK, 48, h back porch (pixels)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, v front porch (lines)
- V_SYNC, 2, v sync width (lines)
- V_BACK, 33, v back porch (lines)

Ports:
- CLOCK_50  in  1  50 MHz system clock
- reset_n  in  1  asynchronous, active-low reset (top level ties it to KEY[0])
- req_x  out  10  column being requested (h counter)
- req_y  out  10  row being requested (v counter)
- req_active  out  1  req_x/req_y inside the visible area
- rgb_in  in  24  {R,G,B} for the last request; sampled at next pixel advance
- frame_start  out  1  one-CLOCK_50 pulse when counters wrap to (0,0)
- line_start  out  1  one-CLOCK_50 pulse when h wraps to 0
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- VGA_HS  out  1  h sync, active low
- VGA_VS  out  1  v sync, active low
- VGA_BLANK_N  out  1  high during visible pixels
- VGA_SYNC_N  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8 each  colour to DAC

## Operation
- H_TOTAL = 800 and V_TOTAL = 525 are derived from the parameters.
- pix_tick toggles every CLOCK_50 edge; reset value is 0.
- A pixel advance is an edge where pix_tick==1.
- On a pixel advance:
  - h_cnt increments, wrapping H_TOTAL-1 -> 0.
  - On h wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
- req_x = h_cnt and req_y = v_cnt, both registered counter values.
- req_active = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- On the same pixel-advance edge, the output stage registers the position being left (h_cnt, v_cnt before increment):
  - VGA_BLANK_N <= req_active.
  - VGA_R/G/B <= req_active ? rgb_in : 0.
  - VGA_HS <= !(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. [656,751].
  - VGA_VS <= !(v_cnt in [490,491]).
- The upstream renderer must present rgb_in for (req_x, req_y) before the next pixel advance. This allows one or two registers upstream.
- VGA_CLK = pix_tick. Data changes on the edge after which VGA_CLK goes low; the DAC samples on the VGA_CLK rising edge, mid-pixel.
- line_start / frame_start are registered pulses, high for exactly one CLOCK_50 after the edge on which h_cnt becomes 0 (frame_start only when v_cnt also becomes 0).
- Reset is asynchronous and immediate, including mid-frame. Reset values:
  - h_cnt = v_cnt = 0, pix_tick = 0.
  - VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, RGB = 0, VGA_CLK = 0.
  - frame_start = line_start = 0.
  - Timing restarts at (0,0) with no partial-frame recovery.

## Timing
- Pixel period is 2 CLOCK_50 cycles; line is 1600 cycles; frame is 840000 cycles (16.8 ms).
- Latency from a request to the pin output is one pixel, 2 CLOCK_50 cycles.
- First pixel advance occurs on the 2nd rising edge after reset_n deasserts.
- HS low for 192 cycles per line; VS low for 3200 cycles per frame.
- Simultaneous h wrap and v wrap: both counters go to 0 on the same edge, and frame_start and line_start both pulse.

## Structure
- Shared include vga_params.vh holds the default timing constants, H_TOTAL/V_TOTAL, and the sync start/end derivations, so the renderer uses the same numbers.
- One sub-module, vga_counter: pix_tick plus h/v counters plus wrap pulses. Output registers live in the top of this block.

## Test plan
- Hold reset_n=0 for 600 ns, then release → outputs stay at reset values until edge 2; req_x becomes 1 at edge 2 and VGA_CLK toggles every edge.
- Free-run one line → VGA_HS falls at the output edge for pixel 656, stays low exactly 192 cycles, and line_start pulses every 1600 cycles.
- Free-run one frame → VGA_VS low for exactly 3200 cycles starting with line 490; frame_start pulses once per 840000 cycles; v_cnt wraps 524 → 0.
- rgb_in = 24'hFF0000 constant → VGA_R = 8'hFF only while VGA_BLANK_N=1 (640 pixels x 480 lines); VGA_R/G/B are 0 in every blanking cycle.
- Renderer model returning rgb_in = {req_x[7:0], req_y[7:0], 8'h5A} → at the pin, the pixel visible at (x,y) carries R=x[7:0], G=y[7:0], B=8'h5A, one pixel after its request.
- Assert reset_n=0 asynchronously mid-frame at v_cnt=200 → all outputs take reset values before the next clock edge; after release, counting restarts at (0,0) and the next frame_start occurs 840000 cycles later.

Source files
------------

// File: rtl/vga_timing_out_pkg.sv
// Raster constants, shared types and helpers for the 640x480@60 VGA output path.
// The renderer imports this package as well, so both sides use the same raster numbers.
package vga_timing_out_pkg;

  localparam int CNT_W = 10;
  localparam int RGB_W = 24;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync windows are inclusive: first and last pixel/line with sync asserted.
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_out_if.sv
// Pixel request bus between the timing stage (master) and the upstream renderer (slave).
// The renderer answers req_x/req_y with rgb_in before the next pixel advance.
interface vga_timing_out_if;
  import vga_timing_out_pkg::*;

  cnt_t             req_x;
  cnt_t             req_y;
  logic             req_active;
  logic [RGB_W-1:0] rgb_in;
  logic             frame_start;
  logic             line_start;

  modport master (
    output req_x,
    output req_y,
    output req_active,
    output frame_start,
    output line_start,
    input  rgb_in
  );

  modport slave (
    input  req_x,
    input  req_y,
    input  req_active,
    input  frame_start,
    input  line_start,
    output rgb_in
  );

endinterface

// File: rtl/vga_counter.sv
// Pixel-enable divider plus horizontal/vertical raster counters.
// Produces registered single-cycle pulses on the edge where h (and v) wrap to zero.
module vga_counter
  import vga_timing_out_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic line_start,
  output logic frame_start
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  logic pix_tick_q, pix_tick_d;
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic h_wrap, v_wrap;

  // Counters move only on edges where pix_tick was already high, i.e. every other edge.
  always_comb begin
    pix_tick_d    = ~pix_tick_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_wrap        = pix_tick_q && (h_cnt_q == H_LAST);
    v_wrap        = h_wrap && (v_cnt_q == V_LAST);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    if (pix_tick_q) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + cnt_t'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_tick_q    <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= pix_tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_timing_out.sv
// Final VGA stage: raster timing from CLOCK_50, pixel requests to the renderer and
// a pin-side register stage that keeps RGB, HS, VS and BLANK_N aligned for the DAC.
module vga_timing_out
  import vga_timing_out_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  vga_timing_out_if.master  pix_if,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_VIS_C        = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS_C        = cnt_t'(V_VISIBLE);
  localparam cnt_t H_SYNC_START_C = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t H_SYNC_END_C   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t V_SYNC_START_C = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t V_SYNC_END_C   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic pix_tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic line_start;
  logic frame_start;
  logic active;

  logic vga_hs_q, vga_hs_d;
  logic vga_vs_q, vga_vs_d;
  logic blank_n_q, blank_n_d;
  rgb_t rgb_q, rgb_d;

  vga_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .clk         (CLOCK_50),
    .rst_n       (reset_n),
    .pix_tick    (pix_tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  assign active = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);

  assign pix_if.req_x       = h_cnt;
  assign pix_if.req_y       = v_cnt;
  assign pix_if.req_active  = active;
  assign pix_if.line_start  = line_start;
  assign pix_if.frame_start = frame_start;

  // The pin stage captures the position being left on each pixel advance, so the colour
  // returned for a request appears exactly one pixel later together with its sync/blank.
  always_comb begin
    vga_hs_d  = vga_hs_q;
    vga_vs_d  = vga_vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pix_tick) begin
      blank_n_d = active;
      rgb_d     = active ? rgb_t'(pix_if.rgb_in) : '0;
      vga_hs_d  = ~in_window(h_cnt, H_SYNC_START_C, H_SYNC_END_C);
      vga_vs_d  = ~in_window(v_cnt, V_SYNC_START_C, V_SYNC_END_C);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs_q  <= 1'b1;
      vga_vs_q  <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      vga_hs_q  <= vga_hs_d;
      vga_vs_q  <= vga_vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  // DAC samples on the rising VGA_CLK edge, midway through each two-cycle pixel.
  assign VGA_CLK     = pix_tick;
  assign VGA_HS      = vga_hs_q;
  assign VGA_VS      = vga_vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench: one default-timing instance for line-level timing and a shrunken
// raster (25x12 totals) instance so whole frames and mid-frame reset fit in a short run.
module tb_vga_timing_out;

  logic clk = 1'b0;
  logic reset_n;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  vga_timing_out_if full_if();
  vga_timing_out_if small_if();

  logic       f_clk, f_hs, f_vs, f_blank_n, f_sync_n;
  logic [7:0] f_r, f_g, f_b;
  logic       s_clk, s_hs, s_vs, s_blank_n, s_sync_n;
  logic [7:0] s_r, s_g, s_b;

  always #10 clk = ~clk;

  assign full_if.rgb_in  = 24'hFF0000;
  assign small_if.rgb_in = {small_if.req_x[7:0], small_if.req_y[7:0], 8'h5A};

  vga_timing_out dut_full (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .pix_if      (full_if),
    .VGA_CLK     (f_clk),
    .VGA_HS      (f_hs),
    .VGA_VS      (f_vs),
    .VGA_BLANK_N (f_blank_n),
    .VGA_SYNC_N  (f_sync_n),
    .VGA_R       (f_r),
    .VGA_G       (f_g),
    .VGA_B       (f_b)
  );

  // Small raster: H 16+2+4+3 = 25 (HS on x 18..21), V 6+2+2+2 = 12 (VS on y 8..9).
  vga_timing_out #(
    .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_VISIBLE (6),  .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
  ) dut_small (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .pix_if      (small_if),
    .VGA_CLK     (s_clk),
    .VGA_HS      (s_hs),
    .VGA_VS      (s_vs),
    .VGA_BLANK_N (s_blank_n),
    .VGA_SYNC_N  (s_sync_n),
    .VGA_R       (s_r),
    .VGA_G       (s_g),
    .VGA_B       (s_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  int hs_fall_k, hs_low, blank_cycles, ls_count, ls_first, ls_second, fs_full;
  int s_vs_fall_k, s_vs_low, s_fs_count, full_bad, small_bad;
  int x, y, p, sx, sy;
  logic f_vis, s_vis, prev_f_hs, prev_s_vs, found;
  logic [23:0] exp_rgb;
  int first_fs;

  initial begin
    reset_n = 1'b0;
    #300;
    checkOutput("rst_hs",      32'(f_hs), 1);
    checkOutput("rst_vs",      32'(f_vs), 1);
    checkOutput("rst_blank",   32'(f_blank_n), 0);
    checkOutput("rst_rgb",     32'({f_r, f_g, f_b}), 0);
    checkOutput("rst_vgaclk",  32'(f_clk), 0);
    checkOutput("rst_req",     32'({full_if.req_x, full_if.req_y}), 0);
    checkOutput("rst_pulses",  32'({full_if.line_start, full_if.frame_start}), 0);
    checkOutput("sync_n",      32'(f_sync_n), 0);
    #300;
    reset_n = 1'b1;

    applyStimulus(1);
    checkOutput("e1_vgaclk", 32'(f_clk), 1);
    checkOutput("e1_req_x",  32'(full_if.req_x), 0);
    checkOutput("e1_blank",  32'(f_blank_n), 0);
    applyStimulus(1);
    checkOutput("e2_req_x",  32'(full_if.req_x), 1);
    checkOutput("e2_vgaclk", 32'(f_clk), 0);

    // k = 0 is the sample just after edge 2; pixel p is on the pins for k = 2p, 2p+1.
    hs_fall_k = -1; hs_low = 0; blank_cycles = 0; ls_count = 0; ls_first = -1; ls_second = -1;
    fs_full = 0; s_vs_fall_k = -1; s_vs_low = 0; s_fs_count = 0; full_bad = 0; small_bad = 0;
    prev_f_hs = 1'b1; prev_s_vs = 1'b1;
    for (int k = 0; k < 3300; k++) begin
      if (k > 0) applyStimulus(1);
      p = k / 2;
      x = p % 800;
      f_vis = (x < 640);
      exp_rgb = f_vis ? 24'hFF0000 : 24'h0;
      if ({f_r, f_g, f_b} !== exp_rgb || f_blank_n !== f_vis || f_clk !== 1'(k % 2) ||
          f_hs !== !(x >= 656 && x <= 751) || f_vs !== 1'b1) full_bad++;
      if (!f_hs && prev_f_hs && hs_fall_k < 0) hs_fall_k = k;
      if (!f_hs && k < 1600) hs_low++;
      if (f_blank_n && k < 3200) blank_cycles++;
      if (full_if.line_start) begin
        ls_count++;
        if (ls_first < 0) ls_first = k;
        else if (ls_second < 0) ls_second = k;
      end
      if (full_if.frame_start) fs_full++;
      prev_f_hs = f_hs;

      sx = p % 25;
      sy = (p / 25) % 12;
      s_vis = (sx < 16) && (sy < 6);
      exp_rgb = s_vis ? {sx[7:0], sy[7:0], 8'h5A} : 24'h0;
      if ({s_r, s_g, s_b} !== exp_rgb || s_blank_n !== s_vis ||
          s_hs !== !(sx >= 18 && sx <= 21) || s_vs !== !(sy >= 8 && sy <= 9)) small_bad++;
      if (!s_vs && prev_s_vs && s_vs_fall_k < 0) s_vs_fall_k = k;
      if (!s_vs && k < 600) s_vs_low++;
      if (small_if.frame_start) s_fs_count++;
      prev_s_vs = s_vs;

      if (k == 160) checkOutput("s_pix_5_3", 32'({s_blank_n, s_r, s_g, s_b}), {8'h01, 8'h05, 8'h03, 8'h5A});
      if (k == 354) checkOutput("s_pix_blank_row7", 32'({s_blank_n, s_r, s_g, s_b}), 0);
      if (k == 597) checkOutput("s_req_last", 32'({small_if.req_x, small_if.req_y}), {10'd24, 10'd11});
      if (k == 598) checkOutput("s_wrap", 32'({small_if.req_x, small_if.req_y, small_if.frame_start, small_if.line_start}), 2'b11);
      if (k == 599) checkOutput("s_fs_width", 32'(small_if.frame_start), 0);
      if (k == 1597) checkOutput("f_req_x_799", 32'(full_if.req_x), 799);
      if (k == 1598) checkOutput("f_hwrap", 32'({full_if.req_x, full_if.req_y}), {10'd0, 10'd1});
    end
    checkOutput("f_hs_fall_k",    hs_fall_k, 1312);
    checkOutput("f_hs_low",       hs_low, 192);
    checkOutput("f_blank_cycles", blank_cycles, 2560);
    checkOutput("f_ls_first",     ls_first, 1598);
    checkOutput("f_ls_period",    ls_second - ls_first, 1600);
    checkOutput("f_ls_count",     ls_count, 2);
    checkOutput("f_no_fs",        fs_full, 0);
    checkOutput("f_model",        full_bad, 0);
    checkOutput("s_vs_fall_k",    s_vs_fall_k, 400);
    checkOutput("s_vs_low",       s_vs_low, 100);
    checkOutput("s_fs_count",     s_fs_count, 5);
    checkOutput("s_model",        small_bad, 0);

    // Asynchronous reset mid-frame while the small raster is at (7,3), inside the visible area.
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      applyStimulus(1);
      if (small_if.req_y == 10'd3 && small_if.req_x == 10'd7) found = 1'b1;
    end
    checkOutput("mid_found", 32'(found), 1);
    #4;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_pins", 32'({s_hs, s_vs, s_blank_n, s_clk}), 4'b1100);
    checkOutput("mid_rst_rgb",  32'({s_r, s_g, s_b}), 0);
    checkOutput("mid_rst_req",  32'({small_if.req_x, small_if.req_y, full_if.req_x}), 0);
    repeat (3) @(posedge clk);
    #10;
    reset_n = 1'b1;

    first_fs = -1;
    for (int e = 1; e <= 700 && first_fs < 0; e++) begin
      applyStimulus(1);
      if (e == 1) checkOutput("re_e1", 32'({s_clk, small_if.req_x}), {1'b1, 10'd0});
      if (e == 2) checkOutput("re_e2", 32'({s_clk, small_if.req_x}), {1'b0, 10'd1});
      if (small_if.frame_start) first_fs = e;
    end
    checkOutput("re_first_fs", first_fs, 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
